// File: rtl/memory_bus_router_pkg.sv
// memory_bus_pkg
// Shared definitions for the memory bus router: the access state machine
// encoding, counter field widths, and a helper that pulls one bank's wait
// state count out of the packed per-bank wait table.
// No ports (package only).
package memory_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } bus_state_t;

  localparam int WAIT_FIELD_BITS = 4;
  localparam int TIMEOUT_BITS    = 8;

  // Wide enough for up to 16 banks of 4-bit wait fields.
  localparam int WAIT_TABLE_BITS = 64;

  // Returns the wait field of one bank; bank n lives at [4n+3:4n].
  function automatic logic [WAIT_FIELD_BITS-1:0] wait_field(
    input logic [WAIT_TABLE_BITS-1:0] wait_table,
    input logic [31:0]                bank
  );
    return wait_table[bank*WAIT_FIELD_BITS +: WAIT_FIELD_BITS];
  endfunction

endpackage

// File: rtl/memory_bus_router_if.sv
// memory_bus_router_if
// Bundles the CPU-side and bank-side bus signals of the router.
//   CPU side : address, data_in, bus_enable, write_enable, error_clear (to router)
//              data_out, bus_halt, bus_error (from router)
//   Bank side: bank_enable, bank_write_enable, bank_data_in (from router)
//              bank_data_out (packed, bank n at [DATA_WIDTH*n +: DATA_WIDTH]),
//              bank_busy (to router)
// The router connects through the 'slave' modport; whatever drives the CPU
// and the banks uses 'master'.
interface memory_bus_router_if #(
  parameter int ADDRESS_WIDTH = 24,
  parameter int DATA_WIDTH    = 8,
  parameter int BANK_BITS     = 2
);
  localparam int NUM_BANKS = 1 << BANK_BITS;

  logic [ADDRESS_WIDTH-1:0]        address;
  logic [DATA_WIDTH-1:0]           data_in;
  logic [DATA_WIDTH-1:0]           data_out;
  logic                            bus_enable;
  logic                            write_enable;
  logic                            bus_halt;
  logic                            bus_error;
  logic                            error_clear;
  logic [NUM_BANKS-1:0]            bank_enable;
  logic [NUM_BANKS-1:0]            bank_write_enable;
  logic [DATA_WIDTH-1:0]           bank_data_in;
  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_data_out;
  logic [NUM_BANKS-1:0]            bank_busy;

  modport slave (
    input  address, data_in, bus_enable, write_enable, error_clear,
           bank_data_out, bank_busy,
    output data_out, bus_halt, bus_error, bank_enable, bank_write_enable,
           bank_data_in
  );

  modport master (
    output address, data_in, bus_enable, write_enable, error_clear,
           bank_data_out, bank_busy,
    input  data_out, bus_halt, bus_error, bank_enable, bank_write_enable,
           bank_data_in
  );

endinterface

// File: rtl/memory_bus_router_timer.sv
// memory_bus_timer
// Wait-state down-counter and timeout up-counter for one bus access.
//   clk, reset   : clock, synchronous active-high reset
//   load_i       : start of a waited access; loads wait_i and zeroes timeout
//   wait_i       : fixed wait states of the selected bank
//   tick_i       : one cycle spent in WAIT
//   wait_done_o  : wait-state count has reached zero
//   timed_out_o  : this WAIT cycle is the TIMEOUT-th cycle of the access
module memory_bus_timer
  import memory_bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_i,
  input  logic [WAIT_FIELD_BITS-1:0] wait_i,
  input  logic                       tick_i,
  output logic                       wait_done_o,
  output logic                       timed_out_o
);

  // The access counts as timed out once the count including the current
  // cycle hits TIMEOUT, so bus_halt is high for exactly TIMEOUT cycles
  // (request cycle plus TIMEOUT-1 WAIT cycles) before the abort cycle.
  localparam int TIMEOUT_LAST_INT = TIMEOUT - 1;
  localparam logic [TIMEOUT_BITS-1:0] TIMEOUT_LAST = TIMEOUT_LAST_INT[TIMEOUT_BITS-1:0];

  logic [WAIT_FIELD_BITS-1:0] wait_cnt_q, wait_cnt_d;
  logic [TIMEOUT_BITS-1:0]    to_cnt_q, to_cnt_d;

  // Both counters saturate so a stuck access cannot wrap them around.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    to_cnt_d   = to_cnt_q;
    if (load_i) begin
      wait_cnt_d = wait_i;
      to_cnt_d   = '0;
    end else if (tick_i) begin
      if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - 1'b1;
      if (to_cnt_q != '1)   to_cnt_d   = to_cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign wait_done_o = (wait_cnt_q == '0);
  assign timed_out_o = (to_cnt_q == TIMEOUT_LAST);

endmodule

// File: rtl/memory_bus_router.sv
// memory_bus_router
// Routes each CPU access to one of 2**BANK_BITS banks, inserting fixed
// per-bank wait states, honouring per-bank busy, blocking writes to
// read-only banks and aborting hung accesses with a sticky error.
//   clk, reset : clock, synchronous active-high reset
//   bus        : memory_bus_router_if.slave (CPU and bank signals)
// Bank select: FAR_BANK when address bits above 15 are nonzero, otherwise
// address[15:16-BANK_BITS]. Read data is registered into data_out.
module memory_bus_router
  import memory_bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 24,
  parameter int DATA_WIDTH    = 8,
  parameter int BANK_BITS     = 2,
  parameter int FAR_BANK      = 3,
  parameter logic [(WAIT_FIELD_BITS << BANK_BITS)-1:0] WAIT_CYCLES = 16'h1000,
  parameter logic [(1 << BANK_BITS)-1:0]               WRITE_MASK  = 4'b0101,
  parameter int TIMEOUT       = 255
) (
  input logic                clk,
  input logic                reset,
  memory_bus_router_if.slave bus
);

  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam logic [BANK_BITS-1:0]       FAR_SEL     = FAR_BANK[BANK_BITS-1:0];
  localparam logic [WAIT_TABLE_BITS-1:0] WAIT_PACKED = 64'(WAIT_CYCLES);

  bus_state_t                 state_q;
  logic [BANK_BITS-1:0]       sel_q;
  logic                       write_q;
  logic [DATA_WIDTH-1:0]      data_out_q;
  logic                       bus_error_q;

  logic [BANK_BITS-1:0]       sel_now;
  logic [WAIT_FIELD_BITS-1:0] wait_now;
  logic                       wr_ok_now;
  logic [BANK_BITS-1:0]       active_sel;
  logic                       write_active;
  logic                       busy_active;
  logic [DATA_WIDTH-1:0]      rdata_active;

  logic [NUM_BANKS-1:0]       bank_enable_c;
  logic [NUM_BANKS-1:0]       bank_write_enable_c;
  logic                       halt_c;
  logic                       complete;
  logic                       blocked;
  logic                       abort;
  logic                       start_wait;

  logic                       wait_done;
  logic                       timed_out;
  logic                       unused_addr_bits;

  // Only the page bits and the bank index bits take part in decoding.
  assign unused_addr_bits = ^bus.address[15-BANK_BITS:0];

  // Address decode for a request presented in IDLE.
  always_comb begin
    sel_now   = (|bus.address[ADDRESS_WIDTH-1:16]) ? FAR_SEL : bus.address[15 -: BANK_BITS];
    wait_now  = wait_field(WAIT_PACKED, 32'(sel_now));
    wr_ok_now = WRITE_MASK[sel_now];
  end

  // While waiting, the bank and direction latched at the request are used;
  // in IDLE the live decode is used so a zero-wait access finishes at once.
  always_comb begin
    active_sel   = (state_q == WAIT) ? sel_q   : sel_now;
    write_active = (state_q == WAIT) ? write_q : bus.write_enable;
    busy_active  = bus.bank_busy[active_sel];
    rdata_active = bus.bank_data_out[DATA_WIDTH*active_sel +: DATA_WIDTH];
  end

  // Per-cycle access decision and the combinational bank strobes. A timeout
  // takes precedence over a completion that lands in the same cycle.
  always_comb begin
    bank_enable_c       = '0;
    bank_write_enable_c = '0;
    halt_c              = 1'b0;
    complete            = 1'b0;
    blocked             = 1'b0;
    abort               = 1'b0;
    start_wait          = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.bus_enable) begin
          bank_enable_c[sel_now] = 1'b1;
          if (bus.write_enable && !wr_ok_now) begin
            blocked = 1'b1;
          end else if (wait_now == '0 && !busy_active) begin
            complete = 1'b1;
          end else begin
            start_wait = 1'b1;
            halt_c     = 1'b1;
          end
        end
      end
      WAIT: begin
        bank_enable_c[sel_q] = 1'b1;
        if (timed_out) begin
          abort = 1'b1;
        end else if (wait_done && !busy_active) begin
          complete = 1'b1;
        end else begin
          halt_c = 1'b1;
        end
      end
      default: ;
    endcase
    if (complete && write_active) bank_write_enable_c[active_sel] = 1'b1;
  end

  memory_bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .load_i      (start_wait),
    .wait_i      (wait_now),
    .tick_i      (state_q == WAIT),
    .wait_done_o (wait_done),
    .timed_out_o (timed_out)
  );

  // Access state machine with the registered read data and sticky error.
  // Setting the error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      write_q     <= 1'b0;
      data_out_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.bus_enable) begin
            sel_q   <= sel_now;
            write_q <= bus.write_enable;
            state_q <= (blocked || complete) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (abort || complete) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (abort) begin
        data_out_q <= '1;
      end else if (complete && !write_active) begin
        data_out_q <= rdata_active;
      end

      if (blocked || abort) begin
        bus_error_q <= 1'b1;
      end else if (bus.error_clear) begin
        bus_error_q <= 1'b0;
      end
    end
  end

  assign bus.bank_enable       = bank_enable_c;
  assign bus.bank_write_enable = bank_write_enable_c;
  assign bus.bus_halt          = halt_c;
  assign bus.data_out          = data_out_q;
  assign bus.bus_error         = bus_error_q;
  assign bus.bank_data_in      = bus.data_in;

endmodule

// File: tb/tb_memory_bus_router.sv
// tb_memory_bus_router
// Self-checking bench for memory_bus_router: a table of directed accesses,
// hand-written multi-cycle sequences (reset mid-access, set/clear collision,
// back-to-back requests) and randomized accesses checked against an
// access-level reference model.
module tb_memory_bus_router;

  localparam int              AddrW      = 24;
  localparam int              DataW      = 8;
  localparam int              BankBits   = 2;
  localparam int              FarCfg     = 3;
  localparam logic [15:0]     WaitCfg    = 16'h1000;
  localparam logic [3:0]      WriteCfg   = 4'b0101;
  localparam int              TimeoutCfg = 255;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  memory_bus_router_if #(
    .ADDRESS_WIDTH (AddrW),
    .DATA_WIDTH    (DataW),
    .BANK_BITS     (BankBits)
  ) bus ();

  logic [7:0] bankMem [4];
  assign bus.bank_data_out = {bankMem[3], bankMem[2], bankMem[1], bankMem[0]};

  memory_bus_router #(
    .ADDRESS_WIDTH (AddrW),
    .DATA_WIDTH    (DataW),
    .BANK_BITS     (BankBits),
    .FAR_BANK      (FarCfg),
    .WAIT_CYCLES   (WaitCfg),
    .WRITE_MASK    (WriteCfg),
    .TIMEOUT       (TimeoutCfg)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] modelData;
  logic       modelErr;

  int   haltCnt;
  int   strobeCnt;
  logic shapeBad;

  typedef struct {
    logic [23:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    int          busy;
    logic        clr;
    int          sel;
    int          halt;
    int          strobe;
    logic [7:0]  data;
    logic        err;
  } vec_t;

  vec_t vecs [12];

  // Compares one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: bank selection and timing from the address map rules.
  function automatic int modelSel(input logic [23:0] a);
    if ((a >> 16) != 0) return FarCfg;
    return int'((a >> 14) % 4);
  endfunction

  function automatic int modelWait(input int sel);
    return int'((WaitCfg >> (4 * sel)) & 16'hF);
  endfunction

  function automatic logic modelWritable(input int sel);
    return ((WriteCfg >> sel) & 4'd1) != 4'd0;
  endfunction

  // Predicts one access: the selected bank busy for the first 'busy' cycles.
  // Completion lands on the first non-busy cycle once wait states have run
  // out; a wait of w costs the request cycle plus w WAIT cycles.
  task automatic predict(input logic [23:0] a, input logic wr, input int busy,
                         output int sel, output int halt, output int strobe);
    int w;
    int done;
    sel    = modelSel(a);
    w      = modelWait(sel);
    halt   = 0;
    strobe = 0;
    if (wr && !modelWritable(sel)) begin
      modelErr = 1'b1;
    end else begin
      done = (w == 0) ? busy : ((w + 1 > busy) ? w + 1 : busy);
      if (done >= TimeoutCfg) begin
        halt      = TimeoutCfg;
        modelData = 8'hFF;
        modelErr  = 1'b1;
      end else begin
        halt = done;
        if (wr) strobe = 1;
        else    modelData = bankMem[sel];
      end
    end
  endtask

  // Drives one access until bus_halt drops (bounded), counting halt cycles
  // and write strobes, and flagging any bank strobe on the wrong bank or in
  // the following DONE cycle.
  task automatic applyStimulus(input logic [23:0] a, input logic wr,
                               input logic [7:0] wdata, input int busy,
                               input int sel, output int halts,
                               output int strobes, output logic bad);
    int   c;
    logic finished;
    halts    = 0;
    strobes  = 0;
    bad      = 1'b0;
    finished = 1'b0;
    c        = 0;
    @(negedge clk);
    bus.address      = a;
    bus.write_enable = wr;
    bus.data_in      = wdata;
    bus.bus_enable   = 1'b1;
    while (!finished && c < 400) begin
      bus.bank_busy      = 4'($urandom);
      bus.bank_busy[sel] = (c < busy);
      #1;
      if (bus.bus_halt) halts++;
      else              finished = 1'b1;
      if (bus.bank_enable != (4'b0001 << sel)) bad = 1'b1;
      if (bus.bank_write_enable != 4'b0000) begin
        if (bus.bank_write_enable == (4'b0001 << sel)) strobes++;
        else                                           bad = 1'b1;
      end
      if (bus.bank_data_in != wdata) bad = 1'b1;
      c++;
      @(negedge clk);
    end
    bus.bus_enable   = 1'b0;
    bus.write_enable = 1'b0;
    bus.bank_busy    = 4'b0000;
    #1;
    if (bus.bus_halt || bus.bank_enable != 4'b0000 || bus.bank_write_enable != 4'b0000)
      bad = 1'b1;
  endtask

  // Pulses error_clear for one idle cycle and expects the flag to drop.
  task automatic clearError();
    @(negedge clk);
    bus.error_clear = 1'b1;
    @(negedge clk);
    bus.error_clear = 1'b0;
    #1;
    checkOutput("error_clear", 32'(bus.bus_error), 32'd0);
    modelErr = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    bus.address      = '0;
    bus.data_in      = '0;
    bus.bus_enable   = 1'b0;
    bus.write_enable = 1'b0;
    bus.error_clear  = 1'b0;
    bus.bank_busy    = '0;
    bankMem[0] = 8'hA5;
    bankMem[1] = 8'h1E;
    bankMem[2] = 8'h2B;
    bankMem[3] = 8'hC3;

    vecs[0]  = '{24'h000100, 1'b0, 8'h00, 0,   1'b0, 0, 0,   0, 8'hA5, 1'b0};
    vecs[1]  = '{24'h010000, 1'b0, 8'h00, 3,   1'b0, 3, 3,   0, 8'hC3, 1'b0};
    vecs[2]  = '{24'h004000, 1'b1, 8'h55, 0,   1'b0, 1, 0,   0, 8'hC3, 1'b1};
    vecs[3]  = '{24'h008004, 1'b1, 8'h3C, 0,   1'b1, 2, 0,   1, 8'hC3, 1'b0};
    vecs[4]  = '{24'h008010, 1'b0, 8'h00, 2,   1'b0, 2, 2,   0, 8'h2B, 1'b0};
    vecs[5]  = '{24'h004321, 1'b0, 8'h00, 1,   1'b0, 1, 1,   0, 8'h1E, 1'b0};
    vecs[6]  = '{24'h00C000, 1'b0, 8'h00, 0,   1'b0, 3, 2,   0, 8'hC3, 1'b0};
    vecs[7]  = '{24'h000000, 1'b0, 8'h00, 0,   1'b0, 0, 0,   0, 8'hA5, 1'b0};
    vecs[8]  = '{24'h800000, 1'b0, 8'h00, 254, 1'b0, 3, 254, 0, 8'hC3, 1'b0};
    vecs[9]  = '{24'h000055, 1'b1, 8'h99, 1,   1'b0, 0, 1,   1, 8'hC3, 1'b0};
    vecs[10] = '{24'h020000, 1'b0, 8'h00, 255, 1'b0, 3, 255, 0, 8'hFF, 1'b1};
    vecs[11] = '{24'h00C000, 1'b1, 8'h11, 0,   1'b1, 3, 0,   0, 8'hFF, 1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset data_out", 32'(bus.data_out), 32'd0);
    checkOutput("reset bus_error", 32'(bus.bus_error), 32'd0);
    checkOutput("reset bus_halt", 32'(bus.bus_halt), 32'd0);
    checkOutput("reset bank_enable", 32'(bus.bank_enable), 32'd0);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].clr) clearError();
      applyStimulus(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].busy,
                    vecs[i].sel, haltCnt, strobeCnt, shapeBad);
      checkOutput($sformatf("vec%0d halt_cycles", i), haltCnt, vecs[i].halt);
      checkOutput($sformatf("vec%0d write_strobes", i), strobeCnt, vecs[i].strobe);
      checkOutput($sformatf("vec%0d strobe_shape", i), 32'(shapeBad), 32'd0);
      checkOutput($sformatf("vec%0d data_out", i), 32'(bus.data_out), 32'(vecs[i].data));
      checkOutput($sformatf("vec%0d bus_error", i), 32'(bus.bus_error), 32'(vecs[i].err));
    end

    // Reset asserted while an access is stuck in WAIT.
    @(negedge clk);
    bus.address    = 24'h030000;
    bus.bus_enable = 1'b1;
    bus.bank_busy  = 4'b1000;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("midwait bus_halt", 32'(bus.bus_halt), 32'd1);
    checkOutput("midwait bank_enable", 32'(bus.bank_enable), 32'h8);
    reset          = 1'b1;
    bus.bus_enable = 1'b0;
    bus.bank_busy  = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("postreset bus_halt", 32'(bus.bus_halt), 32'd0);
    checkOutput("postreset bank_enable", 32'(bus.bank_enable), 32'd0);
    checkOutput("postreset data_out", 32'(bus.data_out), 32'd0);
    checkOutput("postreset bus_error", 32'(bus.bus_error), 32'd0);
    applyStimulus(24'h000100, 1'b0, 8'h00, 0, 0, haltCnt, strobeCnt, shapeBad);
    checkOutput("postreset halt_cycles", haltCnt, 0);
    checkOutput("postreset strobe_shape", 32'(shapeBad), 32'd0);
    checkOutput("postreset data_out_read", 32'(bus.data_out), 32'hA5);

    // Blocked write coinciding with error_clear: the set wins.
    @(negedge clk);
    bus.address      = 24'h004000;
    bus.write_enable = 1'b1;
    bus.data_in      = 8'h77;
    bus.bus_enable   = 1'b1;
    bus.error_clear  = 1'b1;
    #1;
    checkOutput("collide write_strobe", 32'(bus.bank_write_enable), 32'd0);
    checkOutput("collide bus_halt", 32'(bus.bus_halt), 32'd0);
    @(negedge clk);
    bus.bus_enable   = 1'b0;
    bus.write_enable = 1'b0;
    bus.error_clear  = 1'b0;
    #1;
    checkOutput("collide bus_error", 32'(bus.bus_error), 32'd1);
    clearError();

    // Request held through DONE: DONE ignores it, next IDLE serves it again.
    @(negedge clk);
    bus.address    = 24'h000010;
    bus.bus_enable = 1'b1;
    #1;
    checkOutput("b2b first bank_enable", 32'(bus.bank_enable), 32'h1);
    @(negedge clk);
    #1;
    checkOutput("b2b done bank_enable", 32'(bus.bank_enable), 32'd0);
    checkOutput("b2b done bus_halt", 32'(bus.bus_halt), 32'd0);
    checkOutput("b2b done data_out", 32'(bus.data_out), 32'hA5);
    bankMem[0] = 8'h5A;
    @(negedge clk);
    #1;
    checkOutput("b2b second bank_enable", 32'(bus.bank_enable), 32'h1);
    @(negedge clk);
    bus.bus_enable = 1'b0;
    #1;
    checkOutput("b2b second data_out", 32'(bus.data_out), 32'h5A);

    // Randomized accesses against the reference model.
    modelData = 8'h5A;
    modelErr  = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [23:0] a;
      logic        wr;
      logic [7:0]  wd;
      int          b;
      int          sel;
      int          expHalt;
      int          expStrobe;
      if ($urandom_range(0, 3) == 0) clearError();
      for (int k = 0; k < 4; k++) bankMem[k] = 8'($urandom);
      a = 24'($urandom);
      if ($urandom_range(0, 1) == 1) a[23:16] = 8'h00;
      wr = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      b  = int'($urandom_range(0, 4));
      predict(a, wr, b, sel, expHalt, expStrobe);
      applyStimulus(a, wr, wd, b, sel, haltCnt, strobeCnt, shapeBad);
      checkOutput($sformatf("rnd%0d halt_cycles", n), haltCnt, expHalt);
      checkOutput($sformatf("rnd%0d write_strobes", n), strobeCnt, expStrobe);
      checkOutput($sformatf("rnd%0d strobe_shape", n), 32'(shapeBad), 32'd0);
      checkOutput($sformatf("rnd%0d data_out", n), 32'(bus.data_out), 32'(modelData));
      checkOutput($sformatf("rnd%0d bus_error", n), 32'(bus.bus_error), 32'(modelErr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_bus_router.md
Name: memory_bus_router

Overview:
- Parametrised successor to the fixed 4-bank bus decoder.
- Routes each CPU access to one of NUM_BANKS memory/peripheral banks from address bits.
- Inserts per-bank wait states and honours per-bank busy signals.
- Blocks writes to read-only banks and times out hung devices with a sticky error.
- Sits between the W65C832 core and ram/rom/peripherals/sd_card; read data is registered.

Parameters:
- ADDRESS_WIDTH, 24, CPU address width.
- DATA_WIDTH, 8, data bus width.
- BANK_BITS, 2, bank index width; NUM_BANKS = 2**BANK_BITS, index = address[15:16-BANK_BITS].
- FAR_BANK, 3, bank selected whenever address[ADDRESS_WIDTH-1:16] != 0.
- WAIT_CYCLES, 16'h1000, packed 4 bits per bank (bank n at [4n+3:4n]); fixed wait states (default: bank 3 = 1).
- WRITE_MASK, 4'b0101, bit n set = bank n writable.
- TIMEOUT, 255, max cycles an access may spend in WAIT before abort (8-bit counter).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDRESS_WIDTH  CPU address; held stable while bus_halt=1.
- data_in  input  DATA_WIDTH  CPU write data.
- data_out  output  DATA_WIDTH  registered read data.
- bus_enable  input  1  access request.
- write_enable  input  1  1 = write, qualified by bus_enable.
- bus_halt  output  1  stall CPU.
- bus_error  output  1  sticky error flag.
- error_clear  input  1  clears bus_error.
- bank_enable  output  NUM_BANKS  one-hot select to active bank.
- bank_write_enable  output  NUM_BANKS  one-cycle write strobe.
- bank_data_in  output  DATA_WIDTH  data_in passthrough to banks.
- bank_data_out  input  NUM_BANKS*DATA_WIDTH  packed bank read data, bank n at [DATA_WIDTH*n +: DATA_WIDTH].
- bank_busy  input  NUM_BANKS  per-bank not-ready.

Behaviour:
- Reset (synchronous): state=IDLE, data_out=0, bus_error=0, counters=0. Reset takes priority over everything. bank_enable, bank_write_enable and bus_halt read 0 from the cycle after reset is sampled, even mid-access.
- Decode (combinational, from address):
  - sel = FAR_BANK if upper page nonzero, else the bank bits.
  - wait = WAIT_CYCLES[sel]; wr_ok = WRITE_MASK[sel].
- States: IDLE, WAIT, DONE. The sel is latched on leaving IDLE.
- IDLE with bus_enable=1, bank_enable[sel]=1 combinationally. Checks in priority order:
  - Write with wr_ok=0: no strobe; bus_error<=1; go DONE; bus_halt=0. data_out unchanged.
  - wait==0 and bank_busy[sel]==0: complete this cycle. A write pulses bank_write_enable[sel]. A read sets data_out<=bank_data_out[sel]. Go DONE; bus_halt=0.
  - Otherwise: wait_cnt<=wait, to_cnt<=0, go WAIT; bus_halt=1 this cycle.
- WAIT:
  - bank_enable[sel_q]=1, bus_halt=1, to_cnt increments each cycle.
  - wait_cnt decrements to 0 (saturating).
  - When wait_cnt==0 and bank_busy[sel_q]==0: complete as in IDLE. The strobe/capture happens in this cycle, bus_halt=0 in this cycle, then go DONE.
  - Timeout: if to_cnt reaches TIMEOUT first, abort. data_out<={DATA_WIDTH{1'b1}}, bus_error<=1, no write strobe, bus_halt=0, go DONE.
  - Timeout wins over a completion in the same cycle.
- DONE: one cycle; all bank strobes 0, bus_halt=0; return to IDLE. Minimum back-to-back access period is 2 cycles.
- Read latency: data_out valid the cycle after completion and holds until the next read completion.
- bus_error: set by a blocked write or a timeout; cleared by error_clear. If set and clear coincide, set wins.
- bank_busy is only sampled for the selected bank. Busy on unselected banks is ignored.
- bank_data_in = data_in always.

Decomposition:
- Package memory_bus_pkg holds:
  - state enum (IDLE, WAIT, DONE);
  - WAIT_FIELD_BITS=4 and TIMEOUT_BITS=8;
  - a function extracting the per-bank wait field.
- Sub-module memory_bus_timer holds the wait-state down-counter and timeout up-counter.
  - Inputs: load, wait value, tick.
  - Outputs: wait_done, timed_out.

Test Plan:
- Read bank 0 (address 24'h000100, wait 0, busy 0, bank0 data 8'hA5) -> bus_halt never 1; bank_enable=4'b0001 for 1 cycle; data_out=8'hA5 the next cycle.
- Read address 24'h01_0000 (upper page → FAR_BANK 3, wait 1, busy held 3 cycles after request) -> bus_halt high 3 cycles; completion on the first cycle with wait_cnt=0 and busy=0; data_out = bank3 data.
- Write bank 1 (ROM, mask 0) with data 8'h55 -> bank_write_enable stays 0; bus_error=1; then error_clear=1 → bus_error=0 next cycle.
- Write bank 2 (address 24'h008004, data 8'h3C) -> bank_write_enable=4'b0100 for exactly 1 cycle; bank_data_in=8'h3C.
- Bank 3 busy stuck high -> bus_halt high for TIMEOUT cycles; then data_out=8'hFF, bus_error=1, FSM back in IDLE after DONE.
- Assert reset during WAIT -> next cycle bus_halt=0, bank_enable=0, data_out=0, bus_error=0; a new access then completes normally.
